// File: rtl/impartitor_pkg.sv
// -----------------------------------------------------------------------------
// impartitor_pkg
// Shared definitions for the sequential restoring divider:
//   - state_e  : control FSM encoding (IDLE, RUN, FIN, SIGN)
//   - CLA_GRP  : bit width of one carry-lookahead group in the subtractor
//   - clog2()  : width helper used to size the iteration counter
// -----------------------------------------------------------------------------
package impartitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    SIGN = 2'd3
  } state_e;

  localparam int CLA_GRP = 4;

  // Number of bits needed to hold values 0 .. value-1; callers pass WIDTH+1
  // so that the counter can hold WIDTH itself.
  function automatic int clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage : impartitor_pkg

// File: rtl/scazator_cla.sv
// -----------------------------------------------------------------------------
// scazator_cla
// Combinational carry-lookahead subtractor: diff = a - b, computed as
// a + ~b + 1. Bits are grouped in CLA_GRP-bit groups; each group produces a
// group propagate/generate pair and a lookahead stage turns those into the
// group carry-ins. WIDTH need not be a multiple of CLA_GRP: operands are
// zero-extended to whole groups (the padded bits of ~b are ones, so they only
// propagate the carry and leave the carry-out unchanged).
//
// Ports:
//   a      in  WIDTH  minuend
//   b      in  WIDTH  subtrahend
//   diff   out WIDTH  a - b (modulo 2^WIDTH)
//   borrow out 1      1 when a < b (inverted carry-out)
// -----------------------------------------------------------------------------
module scazator_cla
  import impartitor_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NGRP = (WIDTH + CLA_GRP - 1) / CLA_GRP;
  localparam int PW   = NGRP * CLA_GRP;

  logic [PW-1:0]   a_pad;
  logic [PW-1:0]   bn_pad;
  logic [PW-1:0]   p;
  logic [PW-1:0]   g;
  logic [PW-1:0]   sum_pad;
  logic [NGRP-1:0] grp_p;
  logic [NGRP-1:0] grp_g;
  logic [NGRP:0]   grp_c;

  assign a_pad  = PW'(a);
  assign bn_pad = ~(PW'(b));
  assign p      = a_pad ^ bn_pad;
  assign g      = a_pad & bn_pad;

  // Group propagate/generate: G = g3 | p3.g2 | p3.p2.g1 | p3.p2.p1.g0
  always_comb begin : grp_pg
    logic term;
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves it unassigned and no latch is inferred.
    term  = 1'b0;
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_p[k] = &p[k*CLA_GRP +: CLA_GRP];
      for (int i = 0; i < CLA_GRP; i++) begin
        term = g[k*CLA_GRP + i];
        for (int j = i + 1; j < CLA_GRP; j++) begin
          term = term & p[k*CLA_GRP + j];
        end
        grp_g[k] = grp_g[k] | term;
      end
    end
  end

  // Group lookahead: every group carry is a flat sum of products of the
  // lower groups' G/P and the +1 carry-in, not a ripple through groups.
  always_comb begin : grp_lookahead
    logic term;
    logic carry;
    term     = 1'b0;
    carry    = 1'b0;
    grp_c    = '0;
    grp_c[0] = 1'b1;
    for (int k = 1; k <= NGRP; k++) begin
      carry = 1'b1;
      for (int m = 0; m < k; m++) begin
        carry = carry & grp_p[m];
      end
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        carry = carry | term;
      end
      grp_c[k] = carry;
    end
  end

  // In-group carries, again in flat lookahead form from the group carry-in.
  always_comb begin : bit_sum
    logic term;
    logic carry;
    term    = 1'b0;
    carry   = 1'b0;
    sum_pad = '0;
    for (int k = 0; k < NGRP; k++) begin
      for (int i = 0; i < CLA_GRP; i++) begin
        carry = grp_c[k];
        for (int m = 0; m < i; m++) begin
          carry = carry & p[k*CLA_GRP + m];
        end
        for (int j = 0; j < i; j++) begin
          term = g[k*CLA_GRP + j];
          for (int m = j + 1; m < i; m++) begin
            term = term & p[k*CLA_GRP + m];
          end
          carry = carry | term;
        end
        sum_pad[k*CLA_GRP + i] = p[k*CLA_GRP + i] ^ carry;
      end
    end
  end

  // Padding bits of the sum carry no information.
  logic sum_pad_unused;
  assign sum_pad_unused = ^sum_pad;

  assign diff   = sum_pad[WIDTH-1:0];
  assign borrow = ~grp_c[NGRP];

endmodule : scazator_cla

// File: rtl/impartitor_secvential.sv
// -----------------------------------------------------------------------------
// impartitor_secvential
// Multi-cycle restoring divider, one quotient bit per cycle. Each iteration
// shifts {R,Q} left and does a trial subtraction of the divisor through the
// scazator_cla carry-lookahead subtractor; the result is kept only when it
// does not borrow.
//
// Build option: define IMPARTITOR_SIGNED_EN for two's-complement operands
// (magnitudes divided, signs fixed up in an extra SIGN state).
//
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      request strobe, sampled only while busy=0
//   dividend     in  WIDTH  numerator, captured on accept
//   divisor      in  WIDTH  denominator, captured on accept
//   busy         out 1      high from the cycle after accept through done
//   done         out 1      one-cycle pulse, results valid from this cycle
//   quotient     out WIDTH  result quotient (held until next done)
//   remainder    out WIDTH  result remainder (held until next done)
//   div_by_zero  out 1      set with done for divisor==0, cleared on accept
// -----------------------------------------------------------------------------
module impartitor_secvential
  import impartitor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;          // partial remainder R
  logic [WIDTH-1:0] q_q, q_d;          // quotient / shifting dividend Q
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_pend_q, dz_pend_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
`ifdef IMPARTITOR_SIGNED_EN
  logic             q_neg_q, q_neg_d;  // operand signs differ
  logic             r_neg_q, r_neg_d;  // dividend was negative
`endif

  logic             accept;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;
  logic             trial_borrow;

`ifdef IMPARTITOR_SIGNED_EN
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    // The most negative value maps onto itself, which is also its correct
    // unsigned magnitude.
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction
`endif

  // Shift of {R,Q}: R's top bit leaves the window. It is always zero between
  // iterations because R stays below the divisor.
  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign q_sh = {q_q[WIDTH-2:0], 1'b0};

  logic r_top_unused;
  assign r_top_unused = r_q[WIDTH];

  scazator_cla #(
    .WIDTH (WIDTH + 1)
  ) u_scazator_cla (
    .a      (r_sh),
    .b      ({1'b0, divisor_q}),
    .diff   (trial),
    .borrow (trial_borrow)
  );

  // The done cycle still counts as busy, so the earliest new accept is the
  // cycle after done.
  assign accept = (state_q == IDLE) && !done_q && start;

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    q_d           = q_q;
    divisor_d     = divisor_q;
    cnt_d         = cnt_q;
    dz_pend_d     = dz_pend_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
`ifdef IMPARTITOR_SIGNED_EN
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          r_d           = '0;
          cnt_d         = CNT_W'(WIDTH);
          dz_pend_d     = 1'b0;
          div_by_zero_d = 1'b0;
`ifdef IMPARTITOR_SIGNED_EN
          q_d       = magnitude(dividend);
          divisor_d = magnitude(divisor);
          q_neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg_d   = dividend[WIDTH-1];
`else
          q_d       = dividend;
          divisor_d = divisor;
`endif
          if (divisor == '0) begin
            q_d       = '1;
            r_d       = {1'b0, dividend};
            dz_pend_d = 1'b1;
            state_d   = FIN;
          end else begin
            state_d   = RUN;
          end
        end
      end

      RUN: begin
        // Restoring step: keep the trial difference only when it fits.
        r_d   = trial_borrow ? r_sh : trial;
        q_d   = {q_sh[WIDTH-1:1], ~trial_borrow};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef IMPARTITOR_SIGNED_EN
          state_d = SIGN;
`else
          state_d = FIN;
`endif
        end
      end

`ifdef IMPARTITOR_SIGNED_EN
      SIGN: begin
        if (q_neg_q) begin
          q_d = ~q_q + WIDTH'(1);
        end
        if (r_neg_q) begin
          r_d = {1'b0, ~r_q[WIDTH-1:0] + WIDTH'(1)};
        end
        state_d = FIN;
      end
`endif

      FIN: begin
        done_d        = 1'b1;
        quotient_d    = q_q;
        remainder_d   = r_q[WIDTH-1:0];
        div_by_zero_d = dz_pend_q;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed by the always_comb block, whatever the order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      divisor_q     <= '0;
      cnt_q         <= '0;
      dz_pend_q     <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef IMPARTITOR_SIGNED_EN
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      q_q           <= q_d;
      divisor_q     <= divisor_d;
      cnt_q         <= cnt_d;
      dz_pend_q     <= dz_pend_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef IMPARTITOR_SIGNED_EN
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE) || done_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule : impartitor_secvential
